// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: the decoded instruction comes in, the interlock and pipeline-enable controls go out.
interface hazard_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int MAX_LAT = 7,
  parameter int CNT_W   = 16
);
  localparam int LW       = $clog2(MAX_LAT + 1);
  localparam int NUM_REGS = 2 ** AW;

  // There is no valid/ready pair. id_valid marks a live ID instruction. stall is
  // its combinational "not ready" answer in the same cycle. The instruction issues
  // on a clock edge only if id_valid && !flush && !stall && !ext_hold.
  logic                    id_valid;
  logic [NUM_SRC*AW-1:0]   id_src;
  logic [NUM_SRC-1:0]      id_src_en;
  logic [AW-1:0]           id_rd;
  logic                    id_rd_wr;
  logic [LW-1:0]           id_lat;
  logic                    flush;
  logic                    ext_hold;

  logic                    stall;
  logic                    pc_write;
  logic                    if_id_write;
  logic                    id_ex_bubble;
  logic [NUM_REGS-1:0]     busy_mask;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output id_valid, id_src, id_src_en, id_rd, id_rd_wr, id_lat, flush, ext_hold,
    input  stall, pc_write, if_id_write, id_ex_bubble, busy_mask, stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_en, id_rd, id_rd_wr, id_lat, flush, ext_hold,
    output stall, pc_write, if_id_write, id_ex_bubble, busy_mask, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register latency countdown scoreboard.
// It raises a RAW/WAW interlock, drives PC/IF-ID/ID-EX control and counts stall cycles.
module hazard_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int MAX_LAT = 7,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int LW       = $clog2(MAX_LAT + 1);
  localparam int NUM_REGS = 2 ** AW;

  logic [LW-1:0]    cnt_q [NUM_REGS];
  logic [LW-1:0]    cnt_d [NUM_REGS];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic          raw_hit, waw_hit, stall, issue, load_en;
  logic [LW-1:0] lat_c;

  // The clamp only exists when id_lat can encode values above MAX_LAT.
  if (MAX_LAT == (2 ** LW) - 1) begin : g_noclamp
    assign lat_c = bus.id_lat;
  end else begin : g_clamp
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LAT);
    assign lat_c = (bus.id_lat > MAX_L) ? MAX_L : bus.id_lat;
  end

  always_comb begin : raw_check
    logic [AW-1:0] src;
    src     = '0;
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = bus.id_src[i*AW +: AW];
      if (bus.id_src_en[i] && (src != '0) && (cnt_q[src] != '0)) raw_hit = 1'b1;
    end
  end

  assign waw_hit = bus.id_rd_wr && (bus.id_rd != '0) && (cnt_q[bus.id_rd] != '0);
  assign stall   = bus.id_valid && !bus.flush && (raw_hit || waw_hit);
  assign issue   = bus.id_valid && !bus.flush && !stall && !bus.ext_hold;
  assign load_en = issue && bus.id_rd_wr && (bus.id_rd != '0) && (lat_c != '0);

  assign bus.stall        = stall;
  assign bus.pc_write     = !(stall || bus.ext_hold);
  assign bus.if_id_write  = !(stall || bus.ext_hold);
  assign bus.id_ex_bubble = (stall || bus.flush) && !bus.ext_hold;
  assign bus.stall_cnt    = stall_cnt_q;

  // Register 0 is hardwired to zero, so its counter never leaves 0.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!bus.ext_hold) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
        if (load_en && (bus.id_rd == AW'(r))) cnt_d[r] = lat_c;
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !bus.ext_hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) bus.busy_mask[r] = (cnt_q[r] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. The driver queues the expected outputs for each cycle,
// and the negedge monitor compares them.
module tb_hazard_scoreboard;
  localparam int W = 52;  // {stall, pc_write, if_id_write, id_ex_bubble, busy_mask[31:0], stall_cnt[15:0]}

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] b(input int n);
    logic [31:0] m;
    m = 32'd1 << n;
    return m;
  endfunction

  // driver: apply one ID cycle after the edge and queue what the outputs must be
  task automatic step(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] en, input logic [4:0] rd, input logic wr,
                      input logic [2:0] lat, input logic fl, input logic hold,
                      input logic e_st, input logic e_pcw, input logic e_bub,
                      input logic [31:0] e_busy, input logic [15:0] e_sc, input string nm);
    @(posedge clk);
    #1;
    bus.id_valid  = v;
    bus.id_src    = {s1, s0};
    bus.id_src_en = en;
    bus.id_rd     = rd;
    bus.id_rd_wr  = wr;
    bus.id_lat    = lat;
    bus.flush     = fl;
    bus.ext_hold  = hold;
    exp_q.push_back({e_st, e_pcw, e_pcw, e_bub, e_busy, e_sc});
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [31:0] e_busy, input logic [15:0] e_sc, input string nm);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, e_busy, e_sc, nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got, exp;
      string nm;
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.stall, bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.busy_mask, bus.stall_cnt};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h (stall,pcw,ifid,bub,busy,scnt)", nm, got, exp);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.id_valid = 0; bus.id_src = '0; bus.id_src_en = '0; bus.id_rd = '0;
    bus.id_rd_wr = 0; bus.id_lat = '0; bus.flush = 0; bus.ext_hold = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    idle(0, 0, "reset_state");

    // load-use
    step(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 1, 0, 0,    0, "lu_producer");
    step(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 1, 0, 1, b(5), 0, "lu_stall");
    step(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 0, 1, 0, 0,    1, "lu_issue");

    // multicycle latency 4
    step(1, 0, 0, 2'b00, 7, 1, 4, 0, 0, 0, 1, 0, 0,    1, "mc_producer");
    step(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 1, 0, 1, b(7), 1, "mc_stall1");
    step(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 1, 0, 1, b(7), 2, "mc_stall2");
    step(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 1, 0, 1, b(7), 3, "mc_stall3");
    step(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 1, 0, 1, b(7), 4, "mc_stall4");
    step(1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 0,    5, "mc_issue");

    // WAW behind a pending latency-2 write
    step(1, 0, 0, 2'b00, 3, 1, 2, 0, 0, 0, 1, 0, 0,    5, "waw_first");
    step(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 1, 0, 1, b(3), 5, "waw_stall1");
    step(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 1, 0, 1, b(3), 6, "waw_stall2");
    step(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 1, 0, 0,    7, "waw_issue");
    idle(0, 7, "waw_no_entry");

    // ext_hold freezes the countdown and the stall counter
    step(1, 0, 0, 2'b00, 9, 1, 3, 0, 0, 0, 1, 0, 0,    7,  "hold_producer");
    step(1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 1, 0, 0, b(9), 7,  "hold_c1");
    step(1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 1, 0, 0, b(9), 7,  "hold_c2");
    step(1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 1, 0, 0, b(9), 7,  "hold_c3");
    step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1, b(9), 7,  "hold_rel1");
    step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1, b(9), 8,  "hold_rel2");
    step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1, b(9), 9,  "hold_rel3");
    step(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 0,    10, "hold_issue");

    // flush masks the stall without clearing the entry; r0 is never tracked
    step(1, 0, 0, 2'b00, 4, 1, 2, 0, 0, 0, 1, 0, 0,    10, "fl_producer");
    step(1, 4, 0, 2'b01, 0, 0, 0, 1, 0, 0, 1, 1, b(4), 10, "fl_flush");
    step(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1, b(4), 10, "fl_entry_kept");
    step(1, 0, 0, 2'b11, 0, 1, 5, 0, 0, 0, 1, 0, 0,    11, "r0_no_stall");
    idle(0, 11, "r0_no_entry");

    // disabled operand is ignored; then reset mid-countdown
    step(1, 0, 0, 2'b00, 10, 1, 6, 0, 0, 0, 1, 0, 0,    11, "rst_producer");
    step(1, 10, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, b(10), 11, "src_en_off");
    step(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1, b(10), 11, "rst_pre_stall");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy_mask !== '0 || bus.stall_cnt !== '0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL async_reset busy=%h scnt=%0d stall=%b exp busy=0 scnt=0 stall=0",
               bus.busy_mask, bus.stall_cnt, bus.stall);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 10, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 0,     0, "post_rst_discard");
    step(1, 0, 0, 2'b00, 12, 1, 1, 0, 0, 0, 1, 0, 0,     0, "post_rst_load");
    idle(b(12), 0, "post_rst_busy");
    idle(0, 0, "post_rst_clear");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of source operands checked per ID instruction.
REQ-002 SHALL have parameter AW, default 5: register-address width; NUM_REGS = 2**AW.
REQ-003 SHALL have parameter MAX_LAT, default 7: largest result latency accepted; LW = clog2(MAX_LAT+1).
REQ-004 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-006 SHALL have id_valid  in  1  ID stage holds a live instruction.
REQ-007 SHALL have id_src  in  NUM_SRC*AW  packed source addresses, operand i at [i*AW +: AW].
REQ-008 SHALL have id_src_en  in  NUM_SRC  per-operand read enable.
REQ-009 SHALL have id_rd  in  AW  destination address.
REQ-010 SHALL have id_rd_wr  in  1  instruction writes id_rd.
REQ-011 SHALL have id_lat  in  LW  cycles until the result is forwardable (0 = ALU, 1 = load, >1 = multicycle).
REQ-012 SHALL have flush  in  1  squash the ID instruction (branch redirect).
REQ-013 SHALL have ext_hold  in  1  whole-pipeline freeze (memory busy).
REQ-014 SHALL have stall  out  1  RAW/WAW interlock active.
REQ-015 SHALL have pc_write  out  1  PC update enable.
REQ-016 SHALL have if_id_write  out  1  IF/ID register update enable.
REQ-017 SHALL have id_ex_bubble  out  1  load NOP into ID/EX.
REQ-018 SHALL have busy_mask  out  NUM_REGS  bit r set while the register r counter is nonzero.
REQ-019 SHALL have stall_cnt  out  CNT_W  saturating count of interlock stall cycles.

Function
REQ-020 SHALL keep one LW-bit countdown counter per register; register 0 is never tracked (counter fixed at 0).
REQ-021 SHALL compute raw_hit = OR over i of (id_src_en[i] && src_i != 0 && cnt[src_i] != 0).
REQ-022 SHALL compute waw_hit = id_rd_wr && id_rd != 0 && cnt[id_rd] != 0.
REQ-023 SHALL drive stall = id_valid && !flush && (raw_hit || waw_hit), combinationally, in the same cycle.
REQ-024 SHALL drive pc_write = if_id_write = !(stall || ext_hold).
REQ-025 SHALL drive id_ex_bubble = (stall || flush) && !ext_hold.
REQ-026 SHALL define issue = id_valid && !flush && !stall && !ext_hold.
REQ-027 SHALL, on each clock edge with ext_hold low, decrement every nonzero counter by 1.
REQ-028 SHALL, on a clock edge where issue && id_rd_wr && id_rd != 0 && id_lat != 0, load cnt[id_rd] = id_lat; the load overrides the decrement for that register.
REQ-029 SHALL create no entry when id_lat = 0, so an ALU producer never stalls a consumer.
REQ-030 SHALL clamp id_lat > MAX_LAT to MAX_LAT.
REQ-031 SHALL freeze all counters and stall_cnt while ext_hold is high.
REQ-032 SHALL NOT clear counters on flush; flush affects only the ID instruction.
REQ-033 SHALL increment stall_cnt on each edge where stall && !ext_hold, saturating at all ones.
REQ-034 SHALL stall a consumer for exactly id_lat cycles behind a producer issued in the previous cycle; a load (lat 1) costs one bubble.

Reset
REQ-035 SHALL, while rst_n is low, clear all counters, busy_mask and stall_cnt to 0 asynchronously; stall = 0, pc_write = if_id_write = 1 and id_ex_bubble = 0 when id_valid is low.
REQ-036 SHALL discard in-flight entries when reset is asserted mid-operation, and SHALL resume counting on the first edge after rst_n rises.

Verification
REQ-037 SHALL be verified for load-use: issue rd=5 lat=1, next cycle src0=5 -> stall=1, pc_write=0 and id_ex_bubble=1 for 1 cycle, then issue proceeds and stall_cnt=1.
REQ-038 SHALL be verified for multicycle: issue rd=7 lat=4, consumer src1=7 -> 4 stall cycles, and busy_mask[7] clears on the 4th edge.
REQ-039 SHALL be verified for WAW: pending cnt[3]=2 with a new write rd=3 lat=0 -> stall until cnt[3]=0, then rd=3 issues with no new entry.
REQ-040 SHALL be verified for ext_hold: hold for 3 cycles during a lat=3 entry -> the counter stays at its value and releases 3 cycles later than without hold; stall_cnt does not move.
REQ-041 SHALL be verified for flush and r0: a flush while raw_hit -> stall=0 and id_ex_bubble=1; src=0 with rd=0 lat=5 -> no stall and no entry.
REQ-042 SHALL be verified for async reset: assert rst_n low mid-countdown with busy_mask nonzero -> busy_mask=0 and stall_cnt=0 immediately, without waiting for a clock edge.
